complex_divider: RTL and testbench
==================================

// Module: complex_divider
// PURPOSE
//  Sequential Gaussian-integer divider, the inverse of the codebase's packed complex multiplier.
//  It computes q = a / b = a*conj(b) / |b|^2 with truncating division toward zero.
//  Operand packing is {imag[WIDTH-1:WIDTH/2], real[WIDTH/2-1:0]}, each half in two's complement.
//  It uses the same start/done interface as the CMS arithmetic units, with real multi-cycle latency.
// PARAMETERS
//  WIDTH   32   packed operand width; each part is H=WIDTH/2 bits signed; WIDTH must be even and >=4
// PORTS
//  clk          in   1         rising-edge clock (the only clock)
//  reset        in   1         synchronous, active-high
//  start        in   1         request; sampled only in IDLE or DONE
//  a            in   WIDTH     dividend {ai, ar}
//  b            in   WIDTH     divisor  {bi, br}
//  busy         out  1         high from accept through the FIX state
//  done         out  1         level signal; result valid while high
//  div_by_zero  out  1         b==0 for the current result
//  result       out  2*WIDTH   [WIDTH-1:0] = sign-extended real quotient; [2*WIDTH-1:WIDTH] = sign-extended imag quotient
// BEHAVIOUR
//  Reset (synchronous): state=IDLE; busy=0, done=0, div_by_zero=0, result=0.
//   - Reset mid-operation aborts the computation; the next accept starts clean.
//  States and transitions:
//   - IDLE  : on start=1, latch a and b, set busy=1, go to SETUP.
//   - SETUP : compute the two numerators and the denominator (below).
//     - If den==0: result=0, div_by_zero=1, done=1, busy=0, go to DONE.
//     - Otherwise: load magnitudes, counter=WIDTH, go to DIVIDE.
//   - DIVIDE: one restoring-division iteration per cycle for both quotients in parallel.
//     - WIDTH+1 iterations, the divider width being 2H+1 bits.
//     - Shared unsigned den; the last iteration goes to FIX.
//   - FIX   : negate each quotient whose numerator was negative; sign-extend to WIDTH bits.
//     - Register result, done=1, div_by_zero=0, busy=0, go to DONE.
//   - DONE  : hold result, done and div_by_zero.
//     - start=1 is accepted exactly as in IDLE, and done and div_by_zero clear on that edge.
//  Arithmetic:
//   - nr  = ar*br + ai*bi
//   - ni  = ai*br - ar*bi
//   - den = br*br + bi*bi
//   - Products are 2H bits signed, sums 2H+1 bits signed; den is unsigned, at most 2^(2H-1).
//   - Quotients truncate toward zero; remainders are discarded.
//   - |q| <= |a| < 2^H, so H+1 bits always suffice and no overflow or saturation case exists.
//  Latency: take the accepting edge as edge 0.
//   - Normal operation: done=1 is visible after edge WIDTH+3.
//   - b==0: done=1 is visible after edge 1.
//  Boundary conditions:
//   - start while busy=1 is ignored; a and b are not re-sampled.
//   - a and b may change freely after accept.
//   - start held high continuously: back-to-back operations, one accept per DONE entry.
//   - a==0 gives result 0, with the normal latency.
//   - Input extremes (-2^(H-1)) must not overflow intermediate widths.
// TESTING (WIDTH=32)
//  1. a=32'h0005000A (10+5i), b=32'h00020001 (1+2i) -> result={32'hFFFFFFFD,32'h00000004}, done after edge 35.
//  2. a=32'h0000FFF9 (-7), b=32'h00000002 -> real=32'hFFFFFFFD (-3, truncated); imag=0. Also a=7 -> real=3.
//  3. b=0, any a -> div_by_zero=1, result=0, done after edge 1; a following valid start clears the flag.
//  4. a=b=32'h80008000 -> result={32'h0,32'h1}; also a=32'h7FFF8000, b=32'h00000001 -> real=-32768, imag=32767.
//  5. start pulsed at cycles 5 and 10 of a busy operation -> ignored, result from the first operands only; start held high -> consecutive results.
//  6. reset asserted in DIVIDE -> next cycle all outputs 0 and state IDLE; new start yields a correct result with normal latency.

Source files
------------

// File: rtl/complex_divider.sv
// Purpose : sequential Gaussian-integer divider, q = a*conj(b) / |b|^2, truncating toward zero.
// Latency : done visible after accept edge + WIDTH+3 (after accept edge + 1 when b==0).
// Backpr. : start is ignored while busy; a new start is taken in IDLE or while holding a result in DONE.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             request, sampled only in IDLE or DONE
//   a, b              packed operands {imag[WIDTH-1:WIDTH/2], real[WIDTH/2-1:0]}, two's complement halves
//   busy              high from accept until the result is registered
//   done              level, result valid while high
//   div_by_zero       b was zero for the current result
//   result            {sign-extended imag quotient, sign-extended real quotient}
module complex_divider #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero,
    output logic [2*WIDTH-1:0]   result
);

    localparam int H  = WIDTH / 2;
    localparam int D  = WIDTH + 1;            // divider width, 2H+1 bits
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] DIVIDE = 3'd2;
    localparam logic [2:0] FIX    = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]       state;
    logic [WIDTH-1:0] a_q, b_q;
    logic [D-1:0]     den_q;
    logic [D-1:0]     qr_q, qi_q;     // dividend bits shift out the top, quotient bits shift in the bottom
    logic [D-1:0]     rr_q, ri_q;     // partial remainders
    logic             neg_r, neg_i;
    logic [CW-1:0]    cnt;

    // Operands sign-extended to 2H bits so every product is formed at full width.
    logic signed [WIDTH-1:0] ar_x, ai_x, br_x, bi_x;
    logic signed [WIDTH-1:0] p_arbr, p_aibi, p_aibr, p_arbi, p_brbr, p_bibi;
    logic signed [D-1:0]     nr, ni, den_s;
    logic [D-1:0]            mag_nr, mag_ni;
    logic                    den_zero;
    logic [WIDTH-1:0]        fix_r, fix_i;

    always_comb begin
        ar_x = {{H{a_q[H-1]}},     a_q[H-1:0]};
        ai_x = {{H{a_q[WIDTH-1]}}, a_q[WIDTH-1:H]};
        br_x = {{H{b_q[H-1]}},     b_q[H-1:0]};
        bi_x = {{H{b_q[WIDTH-1]}}, b_q[WIDTH-1:H]};

        p_arbr = ar_x * br_x;
        p_aibi = ai_x * bi_x;
        p_aibr = ai_x * br_x;
        p_arbi = ar_x * bi_x;
        p_brbr = br_x * br_x;
        p_bibi = bi_x * bi_x;

        // Sums need one extra bit: two -2^(H-1) squared terms reach 2^(2H-1).
        nr    = {p_arbr[WIDTH-1], p_arbr} + {p_aibi[WIDTH-1], p_aibi};
        ni    = {p_aibr[WIDTH-1], p_aibr} - {p_arbi[WIDTH-1], p_arbi};
        den_s = {p_brbr[WIDTH-1], p_brbr} + {p_bibi[WIDTH-1], p_bibi};

        mag_nr   = nr[D-1] ? -nr : nr;
        mag_ni   = ni[D-1] ? -ni : ni;
        den_zero = (den_s == '0);

        // |q| < 2^H, so the low WIDTH bits already hold the full signed quotient.
        fix_r = neg_r ? -qr_q[WIDTH-1:0] : qr_q[WIDTH-1:0];
        fix_i = neg_i ? -qi_q[WIDTH-1:0] : qi_q[WIDTH-1:0];
    end

    // One restoring step: returns {next remainder, next dividend/quotient}.
    // The remainder stays below den <= 2^(2H-1), so the D-bit difference is exact.
    function automatic logic [2*D-1:0] div_step(input logic [D-1:0] rem,
                                                input logic [D-1:0] quo,
                                                input logic [D-1:0] dv);
        logic [D:0]   sh;
        logic [D-1:0] diff;
        logic         ge;
        sh   = {rem, quo[D-1]};
        ge   = (sh >= {1'b0, dv});
        diff = sh[D-1:0] - dv;
        if (ge)
            return {diff, quo[D-2:0], 1'b1};
        else
            return {sh[D-1:0], quo[D-2:0], 1'b0};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            result      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            den_q       <= '0;
            qr_q        <= '0;
            qi_q        <= '0;
            rr_q        <= '0;
            ri_q        <= '0;
            neg_r       <= 1'b0;
            neg_i       <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q         <= a;
                        b_q         <= b;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        div_by_zero <= 1'b0;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    if (den_zero) begin
                        result      <= '0;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end else begin
                        qr_q  <= mag_nr;
                        qi_q  <= mag_ni;
                        rr_q  <= '0;
                        ri_q  <= '0;
                        den_q <= den_s;
                        neg_r <= nr[D-1];
                        neg_i <= ni[D-1];
                        cnt   <= CW'(WIDTH);
                        state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    {rr_q, qr_q} <= div_step(rr_q, qr_q, den_q);
                    {ri_q, qi_q} <= div_step(ri_q, qi_q, den_q);
                    // cnt runs WIDTH..0, giving WIDTH+1 iterations.
                    if (cnt == '0)
                        state <= FIX;
                    else
                        cnt <= cnt - CW'(1);
                end
                FIX: begin
                    result      <= {fix_i, fix_r};
                    done        <= 1'b1;
                    div_by_zero <= 1'b0;
                    busy        <= 1'b0;
                    state       <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_complex_divider.sv
module tb_complex_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done, div_by_zero;
    logic [63:0] result;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [63:0] res;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    complex_divider #(.WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .div_by_zero(div_by_zero),
        .result(result)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: exact integer arithmetic, truncating division toward zero.
    function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tbv);
        longint ar, ai, br, bi, nr, ni, den, qr, qi;
        exp_t   e;
        ar  = longint'($signed(ta[15:0]));
        ai  = longint'($signed(ta[31:16]));
        br  = longint'($signed(tbv[15:0]));
        bi  = longint'($signed(tbv[31:16]));
        nr  = ar * br + ai * bi;
        ni  = ai * br - ar * bi;
        den = br * br + bi * bi;
        if (den == 0) begin
            e.res = 64'd0;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            qr    = nr / den;
            qi    = ni / den;
            e.res = {qi[31:0], qr[31:0]};
            e.dbz = 1'b0;
            e.lat = 35;
        end
        return e;
    endfunction

    // Count edges after the accept edge until done is seen; pulse start at 5 and 10 if asked.
    task automatic wait_done(input string tag, input bit pulse);
        int   n;
        exp_t e;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            if (pulse) begin
                if (n == 5 || n == 10) begin
                    start = 1'b1;
                    a     = $urandom;
                    b     = $urandom;
                end else begin
                    start = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() == 0) begin
            mismatched++;
            $error("FAIL %s_sb: observed empty scoreboard expected pending entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_lat"},    64'(n),           64'(e.lat));
            check({tag, "_res"},    result,           e.res);
            check({tag, "_dbz"},    64'(div_by_zero), 64'(e.dbz));
            check({tag, "_busy"},   64'(busy),        64'd0);
        end
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input string tag, input bit pulse);
        sb.push_back(model(ta, tbv));
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tbv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        check({tag, "_acc_busy"}, 64'(busy),        64'd1);
        check({tag, "_acc_done"}, 64'(done),        64'd0);
        check({tag, "_acc_dbz"},  64'(div_by_zero), 64'd0);
        wait_done(tag, pulse);
    endtask

    logic [31:0] ext_a [6] = '{32'h80008000, 32'h7FFF7FFF, 32'h80000000, 32'h00008000, 32'hFFFFFFFF, 32'h7FFF8000};
    logic [31:0] ext_b [6] = '{32'h7FFF7FFF, 32'h80008000, 32'h00008000, 32'h80000000, 32'h00010000, 32'hFFFF0003};

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   64'(busy),        64'd0);
        check("rst_done",   64'(done),        64'd0);
        check("rst_dbz",    64'(div_by_zero), 64'd0);
        check("rst_result", result,           64'd0);
        reset = 1'b0;

        // Basic quotient (10+5i)/(1+2i) = 4-3i.
        run_op(32'h0005000A, 32'h00020001, "t1", 1'b0);
        check("t1_const", result, 64'hFFFFFFFD_00000004);

        // Truncation toward zero on both signs.
        run_op(32'h0000FFF9, 32'h00000002, "t2neg", 1'b0);
        check("t2neg_const", result, 64'h00000000_FFFFFFFD);
        run_op(32'h00000007, 32'h00000002, "t2pos", 1'b0);
        check("t2pos_const", result, 64'h00000000_00000003);

        // Divide by zero, then a valid operation clears the flag on accept.
        run_op(32'h12345678, 32'h00000000, "t3dbz", 1'b0);
        check("t3dbz_flag", 64'(div_by_zero), 64'd1);
        run_op(32'h0005000A, 32'h00020001, "t3clr", 1'b0);

        // Input extremes.
        run_op(32'h80008000, 32'h80008000, "t4min", 1'b0);
        check("t4min_const", result, 64'h00000000_00000001);
        run_op(32'h7FFF8000, 32'h00000001, "t4ext", 1'b0);
        check("t4ext_const", result, 64'h00007FFF_FFFF8000);
        for (int i = 0; i < 6; i++) run_op(ext_a[i], ext_b[i], "ext", 1'b0);

        // Zero dividend keeps normal latency.
        run_op(32'h00000000, 32'h00030004, "azero", 1'b0);

        // Start pulses while busy are ignored.
        run_op(32'hFFF6001E, 32'h0003FFFC, "t5pulse", 1'b1);

        // Start held high: back-to-back operations.
        sb.push_back(model(32'h0005000A, 32'h00020001));
        sb.push_back(model(32'h0005000A, 32'h00020001));
        @(negedge clk);
        start = 1'b1;
        a     = 32'h0005000A;
        b     = 32'h00020001;
        @(posedge clk);
        #1;
        wait_done("held1", 1'b0);
        @(posedge clk);
        #1;
        check("held_reacc_done", 64'(done), 64'd0);
        check("held_reacc_busy", 64'(busy), 64'd1);
        wait_done("held2", 1'b0);
        start = 1'b0;

        // Reset during DIVIDE aborts the operation.
        @(negedge clk);
        start = 1'b1;
        a     = 32'h00640032;
        b     = 32'h00010001;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t6_busy",   64'(busy),        64'd0);
        check("t6_done",   64'(done),        64'd0);
        check("t6_dbz",    64'(div_by_zero), 64'd0);
        check("t6_result", result,           64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t6_idle_done", 64'(done), 64'd0);
        run_op(32'h00640032, 32'h00010001, "t6after", 1'b0);

        // Random operands.
        for (int i = 0; i < 16; i++) run_op($urandom, $urandom, "rand", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
